switch_debounce_sync: RTL and testbench

- Conditions the two raw Basys 3 slide-switch inputs (gate input A = SW15, gate input B = SW14) before they reach the logic-gate demonstration blocks.
- Each switch is synchronised into the 100 MHz clock domain and debounced with a stable-period counter.
- Outputs are clean levels plus one-cycle rising/falling strobes.
- Sits directly upstream of the gate block: its debounced A/B outputs drive the gate inputs and the A/B mirror LEDs.

---
 rtl/switch_debounce_sync.sv | 112 +++++++++++
 tb/tb_switch_debounce_sync.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sync.sv
// Slide-switch conditioner for the gate demo: each raw switch (A = SW15,
// B = SW14) is brought into the clock domain through a two-flop chain,
// then accepted as a new level only after it has held steady for
// DEBOUNCE_CYCLES consecutive clocks. Clean levels and one-cycle
// rise/fall strobes are produced, all straight from flops.
module switch_debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic I_P_CLK,
  input  logic I_P_RST,
  input  logic I_P_SW_A,
  input  logic I_P_SW_B,
  output logic O_P_A,
  output logic O_P_B,
  output logic O_P_A_RISE,
  output logic O_P_A_FALL,
  output logic O_P_B_RISE,
  output logic O_P_B_FALL,
  output logic O_P_CHANGE
);

  // Count value at which the next differing cycle commits the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is switch A, channel 1 is switch B.
  logic [1:0]           w_raw;
  logic [1:0]           r_sync1;
  logic [1:0]           r_sync2;
  logic [1:0]           r_deb;
  logic [CNT_WIDTH-1:0] r_cnt [2];
  logic [1:0]           r_rise;
  logic [1:0]           r_fall;
  logic                 r_change;
  logic [1:0]           w_diff;
  logic [1:0]           w_qualify;
  logic [1:0]           w_riseNext;
  logic [1:0]           w_fallNext;

  assign w_raw = {I_P_SW_B, I_P_SW_A};

  // Two-flop synchroniser per switch; only the second stage is used further on.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Decide per channel whether the synchronised level disagrees with the
  // accepted level and whether this is the cycle that commits it.
  always_comb begin
    w_diff     = '0;
    w_qualify  = '0;
    w_riseNext = '0;
    w_fallNext = '0;
    for (int i = 0; i < 2; i++) begin
      w_diff[i]     = r_sync2[i] ^ r_deb[i];
      w_qualify[i]  = w_diff[i] && (r_cnt[i] == CNT_LAST);
      w_riseNext[i] = w_qualify[i] & r_sync2[i];
      w_fallNext[i] = w_qualify[i] & ~r_sync2[i];
    end
  end

  // Stability counter and accepted level: any agreement clears the count,
  // so a bounce shorter than the threshold never reaches the output.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      r_deb <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_diff[i]) begin
          r_cnt[i] <= '0;
        end else if (w_qualify[i]) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Strobes are registered alongside the level so they line up with the
  // first cycle the new level is visible.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      r_rise   <= '0;
      r_fall   <= '0;
      r_change <= 1'b0;
    end else begin
      r_rise   <= w_riseNext;
      r_fall   <= w_fallNext;
      r_change <= |{w_riseNext, w_fallNext};
    end
  end

  assign O_P_A      = r_deb[0];
  assign O_P_B      = r_deb[1];
  assign O_P_A_RISE = r_rise[0];
  assign O_P_A_FALL = r_fall[0];
  assign O_P_B_RISE = r_rise[1];
  assign O_P_B_FALL = r_fall[1];
  assign O_P_CHANGE = r_change;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync with a 4-cycle debounce threshold.
// The reference model tracks, per switch, when the current run of a
// synchronised level started and accepts the level once that run is
// DC clocks long.
module tb_switch_debounce_sync;

  localparam int DC = 4;

  logic I_P_CLK = 1'b0;
  logic I_P_RST = 1'b1;
  logic I_P_SW_A = 1'b0;
  logic I_P_SW_B = 1'b0;
  logic O_P_A, O_P_B, O_P_A_RISE, O_P_A_FALL, O_P_B_RISE, O_P_B_FALL, O_P_CHANGE;

  int checks = 0;
  int errors = 0;

  switch_debounce_sync #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (3)
  ) dut (
    .I_P_CLK   (I_P_CLK),
    .I_P_RST   (I_P_RST),
    .I_P_SW_A  (I_P_SW_A),
    .I_P_SW_B  (I_P_SW_B),
    .O_P_A     (O_P_A),
    .O_P_B     (O_P_B),
    .O_P_A_RISE(O_P_A_RISE),
    .O_P_A_FALL(O_P_A_FALL),
    .O_P_B_RISE(O_P_B_RISE),
    .O_P_B_FALL(O_P_B_FALL),
    .O_P_CHANGE(O_P_CHANGE)
  );

  // 100 MHz clock.
  always #5 I_P_CLK = ~I_P_CLK;

  logic [6:0] obsVec;
  assign obsVec = {O_P_A, O_P_B, O_P_A_RISE, O_P_A_FALL, O_P_B_RISE, O_P_B_FALL, O_P_CHANGE};

  // Reference model state (index 0 = A, 1 = B).
  int         edgeNum = 0;
  logic [1:0] mS1 = '0;
  logic [1:0] mS2 = '0;
  logic [1:0] mDeb = '0;
  logic [1:0] mRise = '0;
  logic [1:0] mFall = '0;
  logic       mChange = 1'b0;
  logic [1:0] runVal = '0;
  int         runStart [2] = '{0, 0};
  logic [6:0] expVec;

  assign expVec = {mDeb[0], mDeb[1], mRise[0], mFall[0], mRise[1], mFall[1], mChange};

  // Advance the model by one rising edge with the inputs that edge sampled.
  function automatic void modelEdge(input logic rst, input logic [1:0] raw);
    logic [1:0] used;
    edgeNum = edgeNum + 1;
    mRise   = '0;
    mFall   = '0;
    mChange = 1'b0;
    if (rst) begin
      mS1    = '0;
      mS2    = '0;
      mDeb   = '0;
      runVal = '0;
      for (int i = 0; i < 2; i++) runStart[i] = edgeNum + 1;
      return;
    end
    used = mS2;
    mS2  = mS1;
    mS1  = raw;
    for (int i = 0; i < 2; i++) begin
      if (used[i] != runVal[i]) begin
        runVal[i]   = used[i];
        runStart[i] = edgeNum;
      end
      if (runVal[i] != mDeb[i] && (edgeNum - runStart[i] + 1) >= DC) begin
        mDeb[i]  = runVal[i];
        mRise[i] = runVal[i];
        mFall[i] = ~runVal[i];
      end
    end
    mChange = |{mRise, mFall};
  endfunction

  // Drive one clock's worth of inputs, let the edge happen, then return at
  // the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic rst, input logic a, input logic b);
    I_P_RST  = rst;
    I_P_SW_A = a;
    I_P_SW_B = b;
    @(posedge I_P_CLK);
    modelEdge(rst, {b, a});
    @(negedge I_P_CLK);
  endtask

  task automatic test_reset;
    int riseAt = -1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checks++;
      if (obsVec !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, obsVec, 7'b0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (i == 5) begin
        checks++;
        if (obsVec !== 7'b1110101) begin
          errors++;
          $display("[TB] FAIL reset_qualify_edge: got %b expected %b", obsVec, 7'b1110101);
        end
      end
      if (O_P_A_RISE === 1'b1 && riseAt < 0) riseAt = i;
    end
    checks++;
    if (riseAt != 5) begin
      errors++;
      $display("[TB] FAIL reset_latency: got %0d expected 5", riseAt);
    end
  endtask

  task automatic test_step_a;
    int riseAt = -1;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL step_settle cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
    end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL step_a cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (O_P_A === 1'b1 && riseAt < 0) riseAt = i;
      if (O_P_A_RISE === 1'b1) pulses++;
    end
    checks++;
    if (riseAt != 5 || pulses != 1) begin
      errors++;
      $display("[TB] FAIL step_latency: got edge %0d pulses %0d expected edge 5 pulses 1", riseAt, pulses);
    end
  endtask

  task automatic test_bounce;
    logic [7:0] pat = 8'b00110011;
    int riseAt = -1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, (i < 8) ? pat[i] : 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL bounce cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (O_P_A_RISE === 1'b1 && riseAt < 0) riseAt = i;
    end
    checks++;
    if (riseAt != 13) begin
      errors++;
      $display("[TB] FAIL bounce_latency: got %0d expected 13", riseAt);
    end
  endtask

  task automatic test_glitch;
    int falls = 0;
    int lowSeen = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, (i < 3) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL glitch cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (O_P_A_FALL === 1'b1) falls++;
      if (O_P_A !== 1'b1) lowSeen++;
    end
    checks++;
    if (falls != 0 || lowSeen != 0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: got falls %0d low %0d expected 0 0", falls, lowSeen);
    end
  endtask

  task automatic test_back_to_back;
    int riseA = -1;
    int riseB = -1;
    int changes = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL simultaneous cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (O_P_A_RISE === 1'b1 && riseA < 0) riseA = i;
      if (O_P_B_RISE === 1'b1 && riseB < 0) riseB = i;
      if (O_P_CHANGE === 1'b1) changes++;
    end
    checks++;
    if (riseA != 5 || riseB != 5 || changes != 1) begin
      errors++;
      $display("[TB] FAIL simultaneous_rise: got A %0d B %0d change %0d expected 5 5 1", riseA, riseB, changes);
    end
  endtask

  task automatic test_reset_midcount;
    int riseAt = -1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== 7'b0) begin
        errors++;
        $display("[TB] FAIL midcount_pre cycle %0d: got %b expected %b", i, obsVec, 7'b0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checks++;
      if (obsVec !== 7'b0) begin
        errors++;
        $display("[TB] FAIL midcount_reset cycle %0d: got %b expected %b", i, obsVec, 7'b0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL midcount_release cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
      if (O_P_A === 1'b1 && riseAt < 0) riseAt = i;
    end
    checks++;
    if (riseAt != 5) begin
      errors++;
      $display("[TB] FAIL midcount_latency: got %0d expected 5", riseAt);
    end
  endtask

  task automatic test_random;
    logic a = 1'b0;
    logic b = 1'b0;
    int holdA = 0;
    int holdB = 0;
    logic rst;
    for (int i = 0; i < 600; i++) begin
      if (holdA == 0) begin
        a = 1'($urandom_range(0, 1));
        holdA = $urandom_range(1, 7);
      end
      if (holdB == 0) begin
        b = 1'($urandom_range(0, 1));
        holdB = $urandom_range(1, 7);
      end
      holdA--;
      holdB--;
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(rst, a, b);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obsVec, expVec);
      end
    end
  endtask

  initial begin
    @(negedge I_P_CLK);
    test_reset();
    test_step_a();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
